// File: rtl/mm_param_pkg.sv
// mm_param_pkg: shared types and helpers for the parametrised MM engine.
//   state_t   : engine FSM states
//   EP_*      : shape-error codes reported on ep (bit0 = A bad, bit1 = B bad)
//   acc_width : accumulator width able to hold MAX_DIM products of two DW values
package mm_param_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        CHECK,
        CALC,
        OUT,
        ERR
    } state_t;

    localparam logic [1:0] EP_OK = 2'b00;
    localparam logic [1:0] EP_A  = 2'b01;
    localparam logic [1:0] EP_B  = 2'b10;
    localparam logic [1:0] EP_AB = 2'b11;

    function automatic int acc_width(input int dw, input int max_dim);
        return 2 * dw + $clog2(max_dim) + 1;
    endfunction

endpackage

// File: rtl/mm_param_mac.sv
// mm_param_mac: clear/enable multiply-accumulate unit.
//   clk, rst : clock, asynchronous active-high reset
//   i_clear  : start a new element (accumulator treated as 0 this cycle)
//   i_en     : add i_a*i_b this cycle
//   i_a, i_b : DW-bit unsigned operands
//   o_res    : low OW bits of the running sum including this cycle's product
//   o_ovf    : running sum (including this cycle) exceeds 2^OW-1
// o_res/o_ovf are combinational look-ahead values so the caller can register
// the finished element on the same edge that performs the last MAC.
module mm_param_mac
    import mm_param_pkg::*;
#(
    parameter int DW = 8,
    parameter int OW = 12,
    parameter int AW = 2 * 8 + 2 + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_en,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [OW-1:0] o_res,
    output logic          o_ovf
);

    logic [AW-1:0]   r_acc;
    logic [2*DW-1:0] w_prod;
    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_sum;

    assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
    assign w_base = i_clear ? '0 : r_acc;
    assign w_sum  = i_en ? (w_base + {{(AW-2*DW){1'b0}}, w_prod}) : w_base;
    assign o_res  = w_sum[OW-1:0];
    assign o_ovf  = |w_sum[AW-1:OW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en || i_clear) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/mm_param_engine.sv
// mm_param_engine: streaming matrix multiplier C = A x B.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : element, consumed on every rising edge while busy==0
//   col_end    : last element of the current row
//   row_end    : last element of the current matrix (also closes the row)
//   busy       : input not accepted (CHECK/CALC/OUT/ERR)
//   valid      : one-cycle strobe qualifying out_data and all flags
//   out_data   : C element, 0 on an illegal-shape strobe
//   change_row : element is the last of its C row
//   overflow   : true sum exceeded 2^OW-1
//   is_legal   : 1 when a product was computed
//   ep         : shape error code (EP_OK/EP_A/EP_B/EP_AB)
// Build option MM_SATURATE_EN: overflowed elements are clamped to all ones
// instead of being truncated; overflow is raised either way.
module mm_param_engine
    import mm_param_pkg::*;
#(
    parameter int DW      = 8,
    parameter int OW      = 12,
    parameter int MAX_DIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          col_end,
    input  logic          row_end,
    output logic          busy,
    output logic          valid,
    output logic [OW-1:0] out_data,
    output logic          change_row,
    output logic          overflow,
    output logic          is_legal,
    output logic [1:0]    ep
);

    localparam int AW = acc_width(DW, MAX_DIM);
    localparam int IW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    // One spare bit so oversize shapes stay distinguishable from MAX_DIM.
    localparam int CW = $clog2(MAX_DIM + 1) + 1;
    localparam logic [CW-1:0] MAXC = CW'(MAX_DIM);

    state_t        r_state;
    logic [DW-1:0] r_a [MAX_DIM][MAX_DIM];
    logic [DW-1:0] r_b [MAX_DIM][MAX_DIM];

    // shape tracking of the matrix being loaded
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_first_len;
    logic          r_bad;

    logic [CW-1:0] r_cols_a, r_rows_a, r_cols_b, r_rows_b;
    logic          r_bad_a, r_bad_b;

    logic [IW-1:0] r_i, r_j, r_k;

    logic          r_busy, r_valid, r_change_row, r_overflow, r_is_legal;
    logic [OW-1:0] r_out_data;
    logic [1:0]    r_ep;

    logic          w_end_col;
    logic [CW-1:0] w_len;
    logic [CW-1:0] w_rows;
    logic [CW-1:0] w_cols;
    logic          w_bad_nxt;
    logic          w_mac_en, w_mac_clear;
    logic [OW-1:0] w_res;
    logic          w_ovf;
    logic [OW-1:0] w_out;
    logic          w_k_last, w_j_last, w_i_last;

    // row_end alone still closes the row
    assign w_end_col = col_end | row_end;
    // saturating counters: oversize rows/matrices are counted, never wrapped
    assign w_len     = (&r_col) ? r_col : r_col + 1'b1;
    assign w_rows    = (&r_row) ? r_row : r_row + 1'b1;
    assign w_cols    = (r_row == '0) ? w_len : r_first_len;
    assign w_bad_nxt = r_bad
                     | (w_end_col && (((r_row != '0) && (w_len != r_first_len)) || (w_len > MAXC)))
                     | (row_end && (w_rows > MAXC));

    assign w_k_last = (CW'(r_k) == r_cols_a - 1'b1);
    assign w_j_last = (CW'(r_j) == r_cols_b - 1'b1);
    assign w_i_last = (CW'(r_i) == r_rows_a - 1'b1);

    assign w_mac_en    = (r_state == CALC);
    assign w_mac_clear = (r_state == CALC) && (r_k == '0);

    mm_param_mac #(
        .DW (DW),
        .OW (OW),
        .AW (AW)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_mac_clear),
        .i_en    (w_mac_en),
        .i_a     (r_a[r_i][r_k]),
        .i_b     (r_b[r_k][r_j]),
        .o_res   (w_res),
        .o_ovf   (w_ovf)
    );

`ifdef MM_SATURATE_EN
    assign w_out = w_ovf ? '1 : w_res;
`else
    assign w_out = w_res;
`endif

    // element storage; out-of-range positions are dropped
    always_ff @(posedge clk) begin
        if ((r_row < MAXC) && (r_col < MAXC)) begin
            if (r_state == LOAD_A) begin
                r_a[r_row[IW-1:0]][r_col[IW-1:0]] <= in_data;
            end else if (r_state == LOAD_B) begin
                r_b[r_row[IW-1:0]][r_col[IW-1:0]] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= LOAD_A;
            r_col        <= '0;
            r_row        <= '0;
            r_first_len  <= '0;
            r_bad        <= 1'b0;
            r_cols_a     <= '0;
            r_rows_a     <= '0;
            r_cols_b     <= '0;
            r_rows_b     <= '0;
            r_bad_a      <= 1'b0;
            r_bad_b      <= 1'b0;
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_out_data   <= '0;
            r_change_row <= 1'b0;
            r_overflow   <= 1'b0;
            r_is_legal   <= 1'b0;
            r_ep         <= EP_OK;
        end else begin
            // strobe outputs default low so flags are 0 whenever valid is 0
            r_valid      <= 1'b0;
            r_out_data   <= '0;
            r_change_row <= 1'b0;
            r_overflow   <= 1'b0;
            r_is_legal   <= 1'b0;
            r_ep         <= EP_OK;

            case (r_state)
                LOAD_A, LOAD_B: begin
                    r_bad <= w_bad_nxt;
                    if (w_end_col) begin
                        r_col <= '0;
                        r_row <= w_rows;
                        if (r_row == '0) begin
                            r_first_len <= w_len;
                        end
                    end else begin
                        r_col <= w_len;
                    end
                    if (row_end) begin
                        r_col       <= '0;
                        r_row       <= '0;
                        r_first_len <= '0;
                        r_bad       <= 1'b0;
                        if (r_state == LOAD_A) begin
                            r_cols_a <= w_cols;
                            r_rows_a <= w_rows;
                            r_bad_a  <= w_bad_nxt;
                            r_state  <= LOAD_B;
                        end else begin
                            r_cols_b <= w_cols;
                            r_rows_b <= w_rows;
                            r_bad_b  <= w_bad_nxt;
                            r_state  <= CHECK;
                            r_busy   <= 1'b1;
                        end
                    end
                end

                CHECK: begin
                    r_i <= '0;
                    r_j <= '0;
                    r_k <= '0;
                    if (r_bad_a || r_bad_b) begin
                        r_state <= ERR;
                        r_valid <= 1'b1;
                        r_ep    <= (r_bad_a && r_bad_b) ? EP_AB : (r_bad_a ? EP_A : EP_B);
                    end else if (r_cols_a != r_rows_b) begin
                        r_state <= ERR;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= CALC;
                    end
                end

                CALC: begin
                    if (w_k_last) begin
                        r_state      <= OUT;
                        r_valid      <= 1'b1;
                        r_is_legal   <= 1'b1;
                        r_out_data   <= w_out;
                        r_overflow   <= w_ovf;
                        r_change_row <= w_j_last;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end

                OUT: begin
                    r_k     <= '0;
                    r_state <= CALC;
                    if (w_j_last) begin
                        r_j <= '0;
                        if (w_i_last) begin
                            r_state <= LOAD_A;
                            r_busy  <= 1'b0;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end

                ERR: begin
                    r_state <= LOAD_A;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= LOAD_A;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign valid      = r_valid;
    assign out_data   = r_out_data;
    assign change_row = r_change_row;
    assign overflow   = r_overflow;
    assign is_legal   = r_is_legal;
    assign ep         = r_ep;

endmodule

// File: tb/tb_mm_param_engine.sv
// tb_mm_param_engine: directed bench for mm_param_engine (DW=8, OW=12, MAX_DIM=4).
module tb_mm_param_engine;

    localparam int DW      = 8;
    localparam int OW      = 12;
    localparam int MAX_DIM = 4;

`ifdef MM_SATURATE_EN
    localparam int OVF_DATA = 'hFFF;
`else
    localparam int OVF_DATA = 'hC02;  // 2*255*255 = 0x1FC02
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          col_end = 1'b0;
    logic          row_end = 1'b0;
    logic          busy, valid, change_row, overflow, is_legal;
    logic [OW-1:0] out_data;
    logic [1:0]    ep;

    int n_tests = 0;
    int n_fail  = 0;
    int q_data[$], q_cr[$], q_ovf[$], q_leg[$], q_ep[$], q_cyc[$];
    int leak;

    always #5 clk = ~clk;

    mm_param_engine #(
        .DW      (DW),
        .OW      (OW),
        .MAX_DIM (MAX_DIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .col_end    (col_end),
        .row_end    (row_end),
        .busy       (busy),
        .valid      (valid),
        .out_data   (out_data),
        .change_row (change_row),
        .overflow   (overflow),
        .is_legal   (is_legal),
        .ep         (ep)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_data = '0; col_end = 1'b0; row_end = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // present one element; returns at the following negedge
    task automatic send(input int d, input bit ce, input bit re);
        in_data = DW'(d); col_end = ce; row_end = re;
        @(negedge clk);
        in_data = '0; col_end = 1'b0; row_end = 1'b0;
    endtask

    // record strobes until n seen or budget cycles elapse; stays on the last strobe's negedge
    task automatic capture(input int n, input int budget);
        q_data.delete(); q_cr.delete(); q_ovf.delete();
        q_leg.delete(); q_ep.delete(); q_cyc.delete();
        leak = 0;
        for (int c = 0; c < budget && q_data.size() < n; c++) begin
            if (valid) begin
                q_data.push_back(int'(out_data));
                q_cr.push_back(int'(change_row));
                q_ovf.push_back(int'(overflow));
                q_leg.push_back(int'(is_legal));
                q_ep.push_back(int'(ep));
                q_cyc.push_back(c);
            end else if (out_data != '0 || change_row || overflow || is_legal || ep != 2'b00) begin
                leak = 1;
            end
            if (q_data.size() < n) @(negedge clk);
        end
    endtask

    task automatic expect_strobe(input string tag, input int idx, input int d, input int cr,
                                 input int ov, input int lg, input int e);
        check({tag, "_data"}, q_data[idx], d);
        check({tag, "_cr"},   q_cr[idx],   cr);
        check({tag, "_ovf"},  q_ovf[idx],  ov);
        check({tag, "_leg"},  q_leg[idx],  lg);
        check({tag, "_ep"},   q_ep[idx],   e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",  int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_data",  int'(out_data), 0);
        check("rst_flags", int'({change_row, overflow, is_legal}), 0);
        check("rst_ep",    int'(ep), 0);

        // 2x2 x 2x2
        do_reset();
        send(1, 0, 0); send(2, 1, 0); send(3, 0, 0); send(4, 1, 1);
        send(5, 0, 0); send(6, 1, 0); send(7, 0, 0); send(8, 1, 1);
        check("t1_busy_after_load", int'(busy), 1);
        capture(4, 40);
        check("t1_count", q_data.size(), 4);
        expect_strobe("t1_e0", 0, 19, 0, 0, 1, 0);
        expect_strobe("t1_e1", 1, 22, 1, 0, 1, 0);
        expect_strobe("t1_e2", 2, 43, 0, 0, 1, 0);
        expect_strobe("t1_e3", 3, 50, 1, 0, 1, 0);
        check("t1_gap", q_cyc[1] - q_cyc[0], 3);
        check("t1_leak", leak, 0);
        @(negedge clk);
        check("t1_busy_end", int'(busy), 0);

        // overflow: [255 255] x [255;255]
        do_reset();
        send(255, 0, 0); send(255, 1, 1);
        send(255, 1, 0); send(255, 1, 1);
        capture(1, 20);
        check("t2_count", q_data.size(), 1);
        expect_strobe("t2", 0, OVF_DATA, 1, 1, 1, 0);

        // ragged A (row lengths 2,3), legal B
        do_reset();
        send(1, 0, 0); send(2, 1, 0); send(3, 0, 0); send(4, 0, 0); send(5, 1, 1);
        send(1, 0, 0); send(1, 1, 0); send(1, 0, 0); send(1, 1, 1);
        capture(1, 20);
        check("t3_count", q_data.size(), 1);
        expect_strobe("t3", 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("t3_busy_end", int'(busy), 0);
        check("t3_valid_end", int'(valid), 0);

        // legal A, ragged B (2,1) -> ep=10
        do_reset();
        send(1, 0, 0); send(2, 1, 0); send(3, 0, 0); send(4, 1, 1);
        send(1, 0, 0); send(1, 1, 0); send(1, 1, 1);
        capture(1, 20);
        check("t4_count", q_data.size(), 1);
        expect_strobe("t4", 0, 0, 0, 0, 0, 2);

        // A 1x5 (cols>MAX), B 5x1 (rows>MAX) -> ep=11
        do_reset();
        for (int i = 0; i < 4; i++) send(1, 0, 0);
        send(1, 1, 1);
        for (int i = 0; i < 4; i++) send(1, 1, 0);
        send(1, 1, 1);
        capture(1, 20);
        check("t5_count", q_data.size(), 1);
        expect_strobe("t5", 0, 0, 0, 0, 0, 3);

        // A 2x3, B 2x2: shapes legal but inner dimension mismatch
        do_reset();
        send(1, 0, 0); send(2, 0, 0); send(3, 1, 0);
        send(4, 0, 0); send(5, 0, 0); send(6, 1, 1);
        send(1, 0, 0); send(2, 1, 0); send(3, 0, 0); send(4, 1, 1);
        capture(1, 20);
        check("t6_count", q_data.size(), 1);
        expect_strobe("t6", 0, 0, 0, 0, 0, 0);

        // MAX_DIM boundary: A 1x4 [1 2 3 4], B 4x1 [5;6;7;8] -> 70
        do_reset();
        send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 1, 1);
        send(5, 1, 0); send(6, 1, 0); send(7, 1, 0); send(8, 1, 1);
        capture(1, 30);
        check("t7_count", q_data.size(), 1);
        expect_strobe("t7", 0, 70, 1, 0, 1, 0);

        // A 1x1 [7] closed by row_end alone, B 1x4 [1 2 3 4]
        do_reset();
        send(7, 0, 1);
        send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 1, 1);
        capture(4, 30);
        check("t8_count", q_data.size(), 4);
        expect_strobe("t8_e0", 0, 7,  0, 0, 1, 0);
        expect_strobe("t8_e1", 1, 14, 0, 0, 1, 0);
        expect_strobe("t8_e2", 2, 21, 0, 0, 1, 0);
        expect_strobe("t8_e3", 3, 28, 1, 0, 1, 0);
        check("t8_gap01", q_cyc[1] - q_cyc[0], 2);
        check("t8_gap23", q_cyc[3] - q_cyc[2], 2);
        check("t8_leak", leak, 0);

        // reset asserted mid-CALC, then a clean reload
        do_reset();
        send(1, 0, 0); send(2, 1, 0); send(3, 0, 0); send(4, 1, 1);
        send(5, 0, 0); send(6, 1, 0); send(7, 0, 0); send(8, 1, 1);
        @(negedge clk);
        check("t9_busy_calc", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("t9_busy_rst", int'(busy), 0);
        check("t9_valid_rst", int'(valid), 0);
        @(negedge clk);
        rst = 1'b0;
        check("t9_busy_reload", int'(busy), 0);
        send(7, 1, 1);
        send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 1, 1);
        capture(4, 30);
        check("t9_count", q_data.size(), 4);
        expect_strobe("t9_e0", 0, 7,  0, 0, 1, 0);
        expect_strobe("t9_e3", 3, 28, 1, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
